bin_to_multi_7seg_scan: RTL
===========================

BIN_TO_MULTI_7SEG_SCAN -- requirements
Module: bin_to_multi_7seg_scan

Interface
REQ-001 SHALL have parameter WIDTH, default 8, binary input width (4..16).
REQ-002 SHALL have parameter DIGITS, default 3, number of displayed digits; 10^DIGITS >= 2^WIDTH and 4*DIGITS >= WIDTH are required.
REQ-003 SHALL have parameter SCAN_DIV, default 4, clock cycles per digit in the scan (>= 1).
REQ-004 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port value, input, WIDTH, binary number to display.
REQ-007 SHALL have port load, input, 1, request to capture value and mode.
REQ-008 SHALL have port mode, input, 1, 0 = decimal and 1 = hexadecimal.
REQ-009 SHALL have port blank_lz, input, 1, which blanks leading zeros when 1.
REQ-010 SHALL have port busy, output, 1, decimal conversion in progress.
REQ-011 SHALL have port done, output, 1, one-cycle pulse when the new result is displayed.
REQ-012 SHALL have port seg, output, 7, segments {a,b,c,d,e,f,g}, active-low.
REQ-013 SHALL have port dig_en, output, DIGITS, one-hot active-low digit enable, with bit 0 the least significant digit.

Function
REQ-014 SHALL implement an FSM with states IDLE and CONV.
REQ-015 SHALL sample load only in IDLE; load while busy=1 is ignored and not queued.
REQ-016 Decimal load (edge E0) SHALL capture value, enter CONV, and set busy=1 after E0.
REQ-017 Decimal conversion SHALL use shift-add-3 (double-dabble), one bit per cycle, with the add-3 rule applied to BCD nibbles >= 5 before each shift.
REQ-018 At edge E_WIDTH, decimal conversion SHALL write the display register, return to IDLE, and set busy=0 and done=1 for exactly one cycle.
REQ-019 Hex load at E0 SHALL write the value nibbles directly to the display register, with nibbles above WIDTH zero-padded; done=1 for one cycle after E0 and busy stays 0.
REQ-020 The display register SHALL hold the previous result throughout CONV, with no intermediate values shown.
REQ-021 A load in the cycle where done=1 SHALL be accepted.
REQ-022 The prescaler SHALL count 0..SCAN_DIV-1 and wrap; on each wrap the digit index advances 0..DIGITS-1 and then wraps to 0.
REQ-023 dig_en SHALL be low only at the bit equal to the digit index.
REQ-024 seg SHALL be decoded from the indexed display digit as follows (active-low abcdefg):
- 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
- 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0001100
- A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
REQ-025 A digit SHALL be blank (seg=1111111) when blank_lz=1, the digit is 0, it is not digit 0, and all more-significant digits are 0.
REQ-026 blank_lz SHALL be evaluated live and not latched.
REQ-027 seg and dig_en SHALL be combinational from registered state only, with no combinational path from value, load, or mode.
REQ-028 Scanning SHALL run continuously, independent of the FSM.

Reset
REQ-029 reset_n=0 SHALL asynchronously force state IDLE, busy=0, done=0, all display digits 0, prescaler 0, and digit index 0.
REQ-030 During and immediately after reset, outputs SHALL be dig_en={DIGITS-1 ones, 0} and seg=0000001.
REQ-031 Reset asserted mid-conversion SHALL abort the conversion with no done pulse; the display reads all zeros.

Verification (WIDTH=8, DIGITS=3, SCAN_DIV=4)
REQ-032 Reset:
- stimulus: assert reset_n=0.
- required: dig_en=110, seg=0000001, busy=0, done=0.
- then: after release, dig_en steps 110->101->011->110 every 4 cycles.
REQ-033 Decimal 255:
- stimulus: load=1, mode=0, value=8'd255.
- required: busy=1 for 8 cycles; done pulse; digits 2/5/5.
- required: digit0 seg=0100100, digit2 seg=0010010.
REQ-034 Leading-zero blanking:
- stimulus: decimal value=7, blank_lz=1.
- required: digit2 and digit1 seg=1111111, digit0 seg=0001111.
- then: with blank_lz=0, digit1 seg=0000001.
REQ-035 Hex:
- stimulus: mode=1, value=8'hAF.
- required: done the cycle after load, busy stays 0.
- required: digit0 seg=0111000, digit1 seg=0001000, digit2 seg=0000001 (1111111 with blank_lz=1).
REQ-036 Load ignored while busy:
- stimulus: decimal 100, then load with value=42 three cycles later.
- required: a single done pulse and display 1/0/0.
- then: load in the done cycle (value=42) produces 0/4/2.
REQ-037 Reset mid-conversion:
- stimulus: assert reset_n during CONV of value=200.
- required: no done pulse, display 0/0/0, busy=0.

Source files
------------

// File: rtl/bin_to_multi_7seg_scan.sv
// rtl/bin_to_multi_7seg_scan.sv - binary to multi-digit seven-segment display with scan
// Decimal loads run a serial double-dabble; hex loads go straight to the display register.
module bin_to_multi_7seg_scan #(
   parameter int WIDTH    = 8,
   parameter int DIGITS   = 3,
   parameter int SCAN_DIV = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [WIDTH-1:0]  value,
   input  logic              load,
   input  logic              mode,
   input  logic              blank_lz,
   output logic              busy,
   output logic              done,
   output logic [6:0]        seg,
   output logic [DIGITS-1:0] dig_en
);
   localparam int DW = 4 * DIGITS;
   localparam int CW = $clog2(WIDTH);
   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic {IDLE, CONV} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [DW-1:0]    bcd_q, bcd_d, bcd_adj, bcd_shifted;
   logic [DW-1:0]    disp_q, disp_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             done_q, done_d;
   logic [PW-1:0]    presc_q;
   logic [IW-1:0]    idx_q;
   logic [3:0]       cur_digit;
   logic             blank;

   always_comb begin
      bcd_adj = bcd_q;
      for (int n = 0; n < DIGITS; n++) begin
         if (bcd_q[n*4 +: 4] >= 4'd5) bcd_adj[n*4 +: 4] = bcd_q[n*4 +: 4] + 4'd3;
      end
      bcd_shifted = {bcd_adj[DW-2:0], shift_q[WIDTH-1]};
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      disp_d  = disp_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (load) begin
               if (mode) begin
                  disp_d = DW'(value);
                  done_d = 1'b1;
               end else begin
                  shift_d = value;
                  bcd_d   = '0;
                  cnt_d   = '0;
                  state_d = CONV;
               end
            end
         end
         CONV: begin
            shift_d = shift_q << 1;
            bcd_d   = bcd_shifted;
            cnt_d   = cnt_q + CW'(1);
            // Display only changes once the last bit has been shifted in.
            if (cnt_q == CW'(WIDTH - 1)) begin
               disp_d  = bcd_shifted;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         shift_q <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         disp_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         disp_q  <= disp_d;
         done_q  <= done_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc_q <= '0;
         idx_q   <= '0;
      end else if (presc_q == PW'(SCAN_DIV - 1)) begin
         presc_q <= '0;
         idx_q   <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
      end else begin
         presc_q <= presc_q + PW'(1);
      end
   end

   assign busy   = (state_q == CONV);
   assign done   = done_q;
   assign dig_en = ~(DIGITS'(1) << idx_q);

   // A digit is a leading zero when it and every more-significant digit are zero.
   always_comb begin
      cur_digit = 4'd0;
      blank     = blank_lz && (idx_q != '0);
      for (int k = 0; k < DIGITS; k++) begin
         if (IW'(k) == idx_q) cur_digit = disp_q[k*4 +: 4];
         if (IW'(k) >= idx_q && disp_q[k*4 +: 4] != 4'd0) blank = 1'b0;
      end
   end

   always_comb begin
      seg = 7'b1111111;
      if (!blank) begin
         case (cur_digit)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0001100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            default: seg = 7'b0111000;
         endcase
      end
   end
endmodule
